// File: rtl/int_pkg.sv
// Shared definitions for the interrupt requester and the local interrupt controller.
package int_pkg;

  localparam int INT_DATA_W = 32;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQ      = 2'd1;
  localparam logic [1:0] ST_WAIT_REL = 2'd2;

endpackage

// File: rtl/int_req_fifo.sv
// Pending-event FIFO: DEPTH x DATA_W, push/pop/flush with occupancy count.
module int_req_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Push,
  input  logic                     Pop,
  input  logic                     Flush,
  input  logic [DATA_W-1:0]        WrData,
  output logic [DATA_W-1:0]        RdData,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wrPtr;
  logic [AW-1:0]     rdPtr;
  logic              pushOk;
  logic              popOk;

  assign Full   = (Count == (AW + 1)'(DEPTH));
  assign Empty  = (Count == '0);
  assign RdData = mem[rdPtr];

  // Fullness is judged after a same-cycle pop; a flush discards the push.
  assign popOk  = Pop && !Empty && !Flush;
  assign pushOk = Push && (!Full || popOk) && !Flush;

  always_ff @(posedge Clk) begin
    if (pushOk) mem[wrPtr] <= WrData;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Count <= '0;
    end else if (Flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      case ({pushOk, popOk})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: Count <= Count;
      endcase
    end
  end

endmodule

// File: rtl/int_req.sv
// Peripheral-side interrupt requester: queues event pulses and presents them
// one at a time over a 4-phase Int/IntAck handshake.
module int_req
  import int_pkg::*;
#(
  parameter int DATA_W = INT_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    EvValid,
  input  logic [DATA_W-1:0]       EvData,
  input  logic                    Flush,
  input  logic                    OvfClr,
  output logic                    Int,
  output logic [DATA_W-1:0]       IntData,
  input  logic                    IntAck,
  output logic [$clog2(DEPTH):0]  Pending,
  output logic                    Overflow
);

  // Handshake: Int rises with IntData stable, stays up until IntAck=1 is
  // sampled, then drops; the next Int waits until IntAck=0 has been sampled.

  logic [1:0]        state;
  logic [1:0]        stateNext;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [DATA_W-1:0] headData;
  logic              popHead;
  logic              dropEv;
  logic              intNext;

  assign popHead = (state == ST_IDLE) && !fifoEmpty && !Flush && !IntAck;
  assign dropEv  = EvValid && fifoFull && !popHead;

  int_req_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .Clk    (Clk),
    .Reset  (Reset),
    .Push   (EvValid),
    .Pop    (popHead),
    .Flush  (Flush),
    .WrData (EvData),
    .RdData (headData),
    .Count  (Pending),
    .Full   (fifoFull),
    .Empty  (fifoEmpty)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:     if (popHead) stateNext = ST_REQ;
      ST_REQ:      if (IntAck)  stateNext = ST_WAIT_REL;
      ST_WAIT_REL: if (!IntAck) stateNext = ST_IDLE;
      default:     stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    intNext = (stateNext == ST_REQ);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Int     <= 1'b0;
      IntData <= '0;
    end else begin
      Int <= intNext;
      if (popHead) IntData <= headData;
    end
  end

  // A drop in the same cycle as OvfClr keeps the flag set.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       Overflow <= 1'b0;
    else if (dropEv) Overflow <= 1'b1;
    else if (OvfClr) Overflow <= 1'b0;
  end

endmodule
